handshake_fifo_break_dvr: RTL and testbench

- Elastic FIFO buffer on a single handshake channel. Placed directly downstream of a handshake constant (or any handshake producer) and upstream of its consumer.
- Breaks all three combinational paths between producer and consumer: data, valid and ready.
- Used on constant-fed operand channels so the constant's pass-through valid/ready does not extend critical paths into the arithmetic units.

---
 rtl/handshake_fifo_break_dvr.sv | 70 +++++++
 tb/tb_handshake_fifo_break_dvr.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/handshake_fifo_break_dvr.sv
// Elastic circular-buffer FIFO that registers data, valid and ready; 1-cycle latency, no fall-through.
// Backpressure: ins_ready drops only when full, outs held stable while outs_ready is low.
module handshake_fifo_break_dvr #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLOTS  = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH-1:0]            ins,
    input  logic                             ins_valid,
    output logic                             ins_ready,
    output logic [DATA_WIDTH-1:0]            outs,
    output logic                             outs_valid,
    input  logic                             outs_ready,
    output logic [$clog2(NUM_SLOTS+1)-1:0]   count
);

    localparam int PTR_W = $clog2(NUM_SLOTS);
    localparam int CNT_W = $clog2(NUM_SLOTS + 1);
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(NUM_SLOTS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(NUM_SLOTS);

    logic [DATA_WIDTH-1:0] r_mem [NUM_SLOTS];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    logic w_push;
    logic w_pop;

    // Handshake outputs decode registered occupancy only, so no input-to-output path exists.
    assign outs_valid = (r_count != '0);
    assign ins_ready  = (r_count != FULL_CNT);
    assign outs       = r_mem[r_rd_ptr];
    assign count      = r_count;

    assign w_push = ins_valid && ins_ready;
    assign w_pop  = outs_valid && outs_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= ins;
                r_wr_ptr <= (r_wr_ptr == LAST_SLOT) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_SLOT) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Overflow/underflow guards; the ready/valid gating makes these unreachable.
    a_no_overflow:  assert property (@(posedge clk) disable iff (rst)
                        !(w_push && !w_pop && r_count == FULL_CNT));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
                        !(w_pop && r_count == '0));

endmodule

// File: tb/tb_handshake_fifo_break_dvr.sv
// Directed bench: 17-bit x 4-slot instance for the main scenarios, 8-bit x 3-slot instance for wrap-around.
module tb_handshake_fifo_break_dvr;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [16:0] a_ins;
    logic        a_ins_valid;
    logic        a_ins_ready;
    logic [16:0] a_outs;
    logic        a_outs_valid;
    logic        a_outs_ready;
    logic [2:0]  a_count;

    logic [7:0]  b_ins;
    logic        b_ins_valid;
    logic        b_ins_ready;
    logic [7:0]  b_outs;
    logic        b_outs_valid;
    logic        b_outs_ready;
    logic [1:0]  b_count;

    handshake_fifo_break_dvr #(.DATA_WIDTH(17), .NUM_SLOTS(4)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .ins        (a_ins),
        .ins_valid  (a_ins_valid),
        .ins_ready  (a_ins_ready),
        .outs       (a_outs),
        .outs_valid (a_outs_valid),
        .outs_ready (a_outs_ready),
        .count      (a_count)
    );

    handshake_fifo_break_dvr #(.DATA_WIDTH(8), .NUM_SLOTS(3)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .ins        (b_ins),
        .ins_valid  (b_ins_valid),
        .ins_ready  (b_ins_ready),
        .outs       (b_outs),
        .outs_valid (b_outs_valid),
        .outs_ready (b_outs_ready),
        .count      (b_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one edge and settle 1ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int nxt;
    int rd;
    int mcnt;
    bit pu;
    bit po;

    initial begin
        a_ins = '0; a_ins_valid = 1'b0; a_outs_ready = 1'b0;
        b_ins = '0; b_ins_valid = 1'b0; b_outs_ready = 1'b0;

        // Reset asserted between edges, observed before any clock edge.
        #3 rst = 1'b1;
        #1;
        chk("rst_outs_valid", 32'(a_outs_valid), 32'd0);
        chk("rst_ins_ready",  32'(a_ins_ready),  32'd1);
        chk("rst_count",      32'(a_count),      32'd0);
        chk("rst_outs",       32'(a_outs),       32'd0);
        chk("rst_b_count",    32'(b_count),      32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_hold_count", 32'(a_count),      32'd0);
            chk("rst_hold_valid", 32'(a_outs_valid), 32'd0);
            chk("rst_hold_ready", 32'(a_ins_ready),  32'd1);
        end
        rst = 1'b0;

        // Single token, consumer always ready.
        a_ins = 17'h080E7; a_ins_valid = 1'b1; a_outs_ready = 1'b1;
        step();
        a_ins_valid = 1'b0;
        chk("single_valid", 32'(a_outs_valid), 32'd1);
        chk("single_data",  32'(a_outs),       32'h080E7);
        chk("single_cnt1",  32'(a_count),      32'd1);
        step();
        chk("single_cnt0",  32'(a_count),      32'd0);
        chk("single_empty", 32'(a_outs_valid), 32'd0);

        // Fill to FULL with the consumer stalled.
        a_outs_ready = 1'b0;
        for (int v = 1; v <= 4; v++) begin
            a_ins = 17'(v); a_ins_valid = 1'b1;
            step();
            chk("fill_count", 32'(a_count), 32'(v));
        end
        chk("full_ready", 32'(a_ins_ready), 32'd0);
        a_ins = 17'h5;
        step();
        chk("full_reject_cnt", 32'(a_count), 32'd4);
        chk("full_head",       32'(a_outs),  32'h1);
        a_outs_ready = 1'b1;
        step();
        chk("unfull_ready", 32'(a_ins_ready), 32'd1);
        chk("unfull_count", 32'(a_count),     32'd3);
        chk("order_2",      32'(a_outs),      32'h2);
        step();
        a_ins_valid = 1'b0;
        chk("push5_count",  32'(a_count), 32'd3);
        chk("order_3",      32'(a_outs),  32'h3);
        step();
        chk("order_4",      32'(a_outs),  32'h4);
        step();
        chk("order_5",      32'(a_outs),  32'h5);
        step();
        chk("drain_empty",  32'(a_outs_valid), 32'd0);

        // Simultaneous push/pop at count=2.
        a_outs_ready = 1'b0; a_ins_valid = 1'b1;
        a_ins = 17'h10; step();
        a_ins = 17'h11; step();
        a_outs_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            a_ins = 17'(32'h12 + k);
            chk("sim_count", 32'(a_count), 32'd2);
            chk("sim_data",  32'(a_outs),  32'(32'h10 + k));
            step();
        end
        a_ins_valid = 1'b0;
        for (int k = 6; k < 8; k++) begin
            chk("sim_tail_valid", 32'(a_outs_valid), 32'd1);
            chk("sim_tail_data",  32'(a_outs),       32'(32'h10 + k));
            step();
        end
        chk("sim_drained", 32'(a_outs_valid), 32'd0);
        a_outs_ready = 1'b0;

        // Wrap-around on the 3-slot instance with random valid/ready.
        nxt = 0; rd = 0; mcnt = 0;
        for (int cyc = 0; cyc < 400 && rd < 20; cyc++) begin
            b_ins_valid  = (nxt < 20) && ($urandom_range(0, 9) < 7);
            b_ins        = 8'(32'hA0 + nxt);
            b_outs_ready = 1'($urandom_range(0, 1));
            chk("wrap_count", 32'(b_count),      32'(mcnt));
            chk("wrap_ready", 32'(b_ins_ready),  32'(mcnt != 3));
            chk("wrap_valid", 32'(b_outs_valid), 32'(mcnt != 0));
            pu = b_ins_valid && (mcnt != 3);
            po = b_outs_ready && (mcnt != 0);
            if (po) begin
                chk("wrap_order", 32'(b_outs), 32'(32'hA0 + rd));
                rd++;
            end
            if (pu) nxt++;
            mcnt = mcnt + int'(pu) - int'(po);
            step();
        end
        b_ins_valid = 1'b0; b_outs_ready = 1'b0;
        chk("wrap_all_out", 32'(rd), 32'd20);

        // Mid-operation reset with three tokens held.
        a_ins_valid = 1'b1;
        a_ins = 17'h21; step();
        a_ins = 17'h22; step();
        a_ins = 17'h23; step();
        a_ins_valid = 1'b0;
        chk("mid_pre_count", 32'(a_count), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("mid_count", 32'(a_count),      32'd0);
        chk("mid_valid", 32'(a_outs_valid), 32'd0);
        chk("mid_ready", 32'(a_ins_ready),  32'd1);
        chk("mid_outs",  32'(a_outs),       32'd0);
        #4 rst = 1'b0;
        step();
        a_ins = 17'h30; a_ins_valid = 1'b1;
        step();
        a_ins_valid = 1'b0;
        chk("post_rst_count", 32'(a_count), 32'd1);
        chk("post_rst_data",  32'(a_outs),  32'h30);
        a_outs_ready = 1'b1;
        step();
        chk("post_rst_empty", 32'(a_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
